avmm_burst_reader: RTL and testbench
====================================

// Module: avmm_burst_reader
// PURPOSE
//   Avalon-MM burst read master serving the on-chip fetch stages (param_fetcher etc.).
//   Accepts a {byte address, beat count} request and issues one or more Avalon bursts to SDRAM.
//   Presents each returned beat with its index on the read-data port.
//   Splits requests longer than MAX_BURST into back-to-back sub-bursts; out_idx runs continuously across them.
// PARAMETERS
//   DATA_W    128  Avalon data width (bits); equals the consumer's SDRAM_W
//   ADDR_W    32   Avalon byte-address width
//   CNT_W     11   width of req_cnt / out_idx
//   MAX_BURST 64   max beats per Avalon burst (power of 2, 1..2^(CNT_W-1))
// PORTS
//   clk               in   1       clock
//   rst               in   1       asynchronous, active-high reset
//   req_start         in   1       1-cycle request pulse; sampled only in IDLE
//   req_addr          in   ADDR_W  byte address of first beat
//   req_cnt           in   CNT_W   total beats requested (0 = empty request)
//   out_valid         out  1       out_data/out_idx valid this cycle
//   out_idx           out  CNT_W   beat index, 0..req_cnt-1
//   out_data          out  DATA_W  beat payload
//   busy              out  1       high from accepted req_start until done
//   done              out  1       1-cycle pulse after last beat (or empty request)
//   avm_address       out  ADDR_W  Avalon byte address
//   avm_read          out  1       Avalon read request
//   avm_burstcount    out  CNT_W   Avalon burst length
//   avm_waitrequest   in   1       Avalon stall
//   avm_readdata      in   DATA_W  Avalon read data
//   avm_readdatavalid in   1       Avalon read data valid
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; avm_address=0; internal counters 0.
//   States: IDLE, REQ, DATA, FIN.
//   IDLE: on req_start latch addr/cnt; remaining=req_cnt; beat=0.
//     cnt==0 -> FIN with no Avalon traffic; else -> REQ. busy=1 from the next cycle.
//   REQ: avm_read=1; avm_address=cur_addr; avm_burstcount=min(remaining, MAX_BURST).
//     Address, burstcount and read are held stable while avm_waitrequest=1.
//     Cycle with avm_read & !avm_waitrequest = accepted -> DATA; avm_read drops the next cycle.
//     sub_left=burstcount.
//   DATA: each avm_readdatavalid beat:
//     out_valid=1 next cycle; out_data=readdata; out_idx=beat (registered, latency 1).
//     Then beat+=1; sub_left-=1; remaining-=1.
//     Last beat of a sub-burst: remaining!=0 -> REQ with cur_addr += MAX_BURST*DATA_W/8; remaining==0 -> FIN.
//     No new burst is issued before the previous one fully returns (max one outstanding).
//   FIN: done=1 for exactly 1 cycle, busy=0 the same cycle; -> IDLE.
//     req_start is accepted again in the cycle after FIN.
//   Consumer timing: the last beat's out_valid precedes the done pulse by >=1 cycle.
//   Consumer timing: consecutive beats can be back-to-back (out_valid high for successive cycles).
//   req_start while busy: ignored; the latched request is unaffected.
//   avm_readdatavalid in IDLE/REQ/FIN: ignored; no out_valid produced.
//   Address arithmetic: ADDR_W-bit modulo wrap; address alignment is the requester's responsibility.
//   out_idx width: out_idx never exceeds req_cnt-1; no wrap for legal req_cnt < 2^CNT_W.
//   rst mid-transfer: immediate return to IDLE, all outputs 0; in-flight Avalon beats are dropped.
//     In-flight Avalon beats arriving after reset are ignored.
// TESTING
//   1) req_addr=0x1000, cnt=1, no waitrequest, data 1 cycle after accept:
//      -> single burst bc=1; out_valid once with idx=0; done 1 cycle after that beat.
//   2) cnt=2, waitrequest high 3 cycles:
//      -> address/bc=2/read held 3 cycles; accepted on cycle 4; idx 0,1 back-to-back; then done.
//   3) cnt=130, MAX_BURST=64:
//      -> bursts bc=64@0x0, bc=64@0x400, bc=2@0x800; out_idx 0..129 contiguous; one done pulse.
//   4) cnt=0 -> no avm_read; done pulse 2 cycles after req_start; busy high for 1 cycle.
//   5) Gapped readdatavalid (every other cycle) with a second req_start mid-transfer:
//      -> gaps mirrored on out_valid; second request ignored.
//      -> stray readdatavalid in IDLE yields no out_valid.
//   6) rst asserted during DATA after beat 3 of 8:
//      -> outputs 0 immediately; late beats ignored; a new request afterwards completes normally from idx 0.

Source files
------------

// File: rtl/avmm_burst_reader.sv
// Avalon-MM burst read master.
// Takes a {byte address, beat count} request and fetches it from SDRAM as one
// or more Avalon bursts of at most MAX_BURST beats, with one burst outstanding
// at a time. Each returned beat is presented one cycle later on out_data
// together with its running index, which counts continuously across sub-bursts.
//
// Handshake: a request is taken when req_start is high while the block is idle.
// Valid/ready on the Avalon side: a read command is transferred in the cycle
// where avm_read=1 and avm_waitrequest=0. Until then, address, burstcount and
// read are held stable. Read data is consumed in every cycle where
// avm_readdatavalid=1 while a burst is outstanding. out_valid is a pure
// strobe: the consumer has no backpressure.
module avmm_burst_reader #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 11,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_start,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [CNT_W-1:0]  req_cnt,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [CNT_W-1:0]  avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_t;

  // Beats per full burst, and the byte distance between consecutive bursts.
  localparam logic [CNT_W-1:0]  MAX_BC = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(MAX_BURST * DATA_W / 8);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cur_addr;
  logic [CNT_W-1:0]    remaining;
  logic [CNT_W-1:0]    beat;
  logic [CNT_W-1:0]    sub_left;
  logic [CNT_W-1:0]    bc_calc;
  logic                accept;
  logic                beat_in;
  logic                sub_last;

  // Burst length for the next command, and the per-cycle events that advance
  // the transfer.
  always_comb begin
    bc_calc  = (remaining > MAX_BC) ? MAX_BC : remaining;
    accept   = (state == REQ) && !avm_waitrequest;
    beat_in  = (state == DATA) && avm_readdatavalid;
    sub_last = beat_in && (sub_left == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the Avalon command outputs.
  always_comb begin
    state_nxt      = state;
    avm_read       = 1'b0;
    avm_address    = cur_addr;
    avm_burstcount = '0;
    case (state)
      IDLE: begin
        if (req_start) state_nxt = (req_cnt == '0) ? FIN : REQ;
      end
      REQ: begin
        avm_read       = 1'b1;
        avm_burstcount = bc_calc;
        if (accept) state_nxt = DATA;
      end
      DATA: begin
        if (sub_last) state_nxt = (remaining == CNT_W'(1)) ? FIN : REQ;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, beat counting, output beat register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      beat      <= '0;
      sub_left  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_start) begin
            cur_addr  <= req_addr;
            remaining <= req_cnt;
            beat      <= '0;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          if (accept) sub_left <= bc_calc;
        end
        DATA: begin
          if (beat_in) begin
            out_valid <= 1'b1;
            out_data  <= avm_readdata;
            out_idx   <= beat;
            beat      <= beat + CNT_W'(1);
            sub_left  <= sub_left - CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
            // The next sub-burst starts one full burst further on.
            if (sub_last && (remaining != CNT_W'(1))) cur_addr <= cur_addr + STEP;
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_burst_reader.sv
// Bench for avmm_burst_reader: an Avalon slave responder, an output monitor,
// and a directed/random request sequence checked against a request-level model.
module tb_avmm_burst_reader;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 11;
  localparam int MAXB   = 64;
  localparam int STEP   = MAXB * DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_start = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [CNT_W-1:0]  req_cnt = '0;
  logic              out_valid;
  logic [CNT_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [CNT_W-1:0]  avm_burstcount;
  logic              avm_waitrequest = 1'b0;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  avmm_burst_reader dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr), .req_cnt(req_cnt),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload the slave returns for a given burst address and beat offset.
  function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] a, input int off);
    return {a, 32'(off) ^ 32'hc0de_0000, a ^ 32'h5a5a_1234, a + 32'(off) * 32'd977};
  endfunction

  // ---------------- Avalon slave responder ----------------
  logic [DATA_W-1:0] pend_q[$];
  logic [31:0]       acc_addr_q[$];
  logic [CNT_W-1:0]  acc_bc_q[$];
  int                acc_rd_q[$];
  bit                acc_stable_q[$];
  int                overlap_cnt = 0;
  int                wait_cfg = 0;
  bit                gap_mode = 1'b0;
  bit                gap_tog = 1'b0;
  bit                stray = 1'b0;
  bit                in_req = 1'b0;
  bit                stable = 1'b1;
  int                wait_left = 0;
  int                rd_cyc = 0;
  logic [31:0]       cur_a = '0;
  logic [CNT_W-1:0]  cur_bc = '0;

  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (stray) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = {4{$urandom}};
      stray = 1'b0;
    end else if (pend_q.size() > 0) begin
      if (!gap_mode || !gap_tog) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pend_q.pop_front();
      end
      gap_tog = gap_mode ? ~gap_tog : 1'b0;
    end
    if (avm_read) begin
      if (!in_req) begin
        in_req = 1'b1;
        cur_a = avm_address;
        cur_bc = avm_burstcount;
        rd_cyc = 0;
        stable = 1'b1;
        wait_left = wait_cfg;
        if (pend_q.size() > 0) overlap_cnt++;
      end
      rd_cyc++;
      if (avm_address != cur_a || avm_burstcount != cur_bc) stable = 1'b0;
      if (wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
      end else begin
        avm_waitrequest = 1'b0;
        acc_addr_q.push_back(cur_a);
        acc_bc_q.push_back(cur_bc);
        acc_rd_q.push_back(rd_cyc);
        acc_stable_q.push_back(stable);
        for (int off = 0; off < int'(cur_bc); off++) pend_q.push_back(beat_data(cur_a, off));
        in_req = 1'b0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      in_req = 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  logic [CNT_W-1:0]  obs_idx_q[$];
  logic [DATA_W-1:0] obs_data_q[$];
  int                obs_cyc_q[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                busy_cnt = 0;
  int                db_overlap = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      obs_idx_q.push_back(out_idx);
      obs_data_q.push_back(out_data);
      obs_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (done && busy) db_overlap++;
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_obs();
    obs_idx_q.delete();
    obs_data_q.delete();
    obs_cyc_q.delete();
    acc_addr_q.delete();
    acc_bc_q.delete();
    acc_rd_q.delete();
    acc_stable_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
    db_overlap = 0;
    overlap_cnt = 0;
  endtask

  task automatic start_req(input logic [31:0] addr, input int cnt);
    clear_obs();
    req_addr = addr;
    req_cnt = CNT_W'(cnt);
    req_start = 1'b1;
    start_cyc = cyc;
    tick(1);
    req_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick(1);
    tick(3);
    chk("done_seen", done_cnt != 0, 1);
  endtask

  task automatic chk_outputs_zero();
    chk("zero_out_valid", out_valid, 0);
    chk("zero_out_idx", out_idx, 0);
    chk("zero_out_data", out_data, 0);
    chk("zero_busy", busy, 0);
    chk("zero_done", done, 0);
    chk("zero_avm_read", avm_read, 0);
    chk("zero_avm_address", avm_address, 0);
    chk("zero_avm_burstcount", avm_burstcount, 0);
  endtask

  // Request-level model: bursts of min(remaining, MAXB) beats at base + k*STEP,
  // beats numbered 0..cnt-1, one done pulse after the last beat.
  task automatic check_xfer(input logic [31:0] addr, input int cnt, input int waits);
    logic [DATA_W-1:0] exp_q[$];
    logic [31:0] a;
    int rem;
    int k;
    int nb;
    rem = cnt;
    a = addr;
    k = 0;
    while (rem > 0) begin
      nb = (rem > MAXB) ? MAXB : rem;
      if (k < acc_addr_q.size()) begin
        chk("burst_addr", acc_addr_q[k], a);
        chk("burst_count", acc_bc_q[k], nb);
        chk("burst_hold", acc_stable_q[k], 1);
        chk("burst_read_cycles", acc_rd_q[k], waits + 1);
      end
      a = a + 32'(STEP);
      rem = rem - nb;
      k++;
    end
    chk("burst_total", acc_addr_q.size(), k);
    for (int i = 0; i < cnt; i++) exp_q.push_back(beat_data(addr + 32'(i / MAXB) * 32'(STEP), i % MAXB));
    chk("beat_total", obs_data_q.size(), cnt);
    for (int i = 0; i < cnt && i < obs_data_q.size(); i++) begin
      chk("beat_idx", obs_idx_q[i], i);
      chk("beat_data", obs_data_q[i], exp_q[i]);
    end
    chk("done_pulses", done_cnt, 1);
    if (obs_cyc_q.size() > 0) chk("done_after_last", done_cyc > obs_cyc_q[obs_cyc_q.size()-1], 1);
    chk("one_outstanding", overlap_cnt, 0);
    chk("busy_low_at_done", db_overlap, 0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [31:0] a;
    int n;
    // Reset state.
    tick(2);
    chk_outputs_zero();
    rst = 1'b0;
    tick(2);
    chk_outputs_zero();

    // Single beat, no waitrequest.
    wait_cfg = 0;
    gap_mode = 1'b0;
    start_req(32'h1000, 1);
    wait_done(50);
    check_xfer(32'h1000, 1, 0);
    if (obs_cyc_q.size() == 1) chk("t1_done_latency", done_cyc - obs_cyc_q[0], 1);

    // Two beats behind three stall cycles.
    wait_cfg = 3;
    start_req(32'h2000, 2);
    wait_done(50);
    check_xfer(32'h2000, 2, 3);
    if (obs_cyc_q.size() == 2) chk("t2_back_to_back", obs_cyc_q[1] - obs_cyc_q[0], 1);

    // Request split into 64 + 64 + 2.
    wait_cfg = 1;
    start_req(32'h0, 130);
    wait_done(1000);
    check_xfer(32'h0, 130, 1);

    // Empty request.
    wait_cfg = 0;
    start_req(32'h3000, 0);
    wait_done(20);
    chk("t4_done_latency", done_cyc - start_cyc, 2);
    chk("t4_busy_cycles", busy_cnt, 1);
    chk("t4_no_bursts", acc_addr_q.size(), 0);
    chk("t4_no_beats", obs_data_q.size(), 0);
    chk("t4_done_pulses", done_cnt, 1);

    // Gapped read data plus an ignored second request.
    gap_mode = 1'b1;
    a = $urandom & 32'hffff_fff0;
    start_req(a, 8);
    for (int i = 0; i < 200 && obs_data_q.size() < 2; i++) tick(1);
    req_addr = 32'hdead_0000;
    req_cnt = CNT_W'(5);
    req_start = 1'b1;
    tick(1);
    req_start = 1'b0;
    wait_done(200);
    check_xfer(a, 8, 0);
    for (int i = 0; i + 1 < obs_cyc_q.size(); i++) chk("t5_gap", obs_cyc_q[i+1] - obs_cyc_q[i], 2);
    gap_mode = 1'b0;
    tick(2);
    clear_obs();
    stray = 1'b1;
    tick(4);
    chk("t5_stray_ignored", obs_data_q.size(), 0);
    chk("t5_idle_not_busy", busy_cnt, 0);

    // Reset in the middle of the data phase.
    a = $urandom & 32'hffff_fff0;
    start_req(a, 8);
    for (int i = 0; i < 200 && obs_data_q.size() < 3; i++) tick(1);
    chk("t6_three_beats", obs_data_q.size() >= 3, 1);
    rst = 1'b1;
    #1;
    chk_outputs_zero();
    clear_obs();
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 50 && pend_q.size() > 0; i++) tick(1);
    tick(3);
    chk("t6_late_beats_dropped", obs_data_q.size(), 0);
    chk("t6_no_done", done_cnt, 0);
    chk("t6_no_new_burst", acc_addr_q.size(), 0);
    a = $urandom & 32'hffff_fff0;
    start_req(a, 4);
    wait_done(100);
    check_xfer(a, 4, 0);

    // Random requests.
    for (int r = 0; r < 5; r++) begin
      a = $urandom & 32'hffff_fff0;
      n = $urandom_range(1, 150);
      wait_cfg = $urandom_range(0, 3);
      gap_mode = 1'($urandom_range(0, 1));
      start_req(a, n);
      wait_done(2000);
      check_xfer(a, n, wait_cfg);
      for (int i = 0; i < 50 && pend_q.size() > 0; i++) tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
